// File: rtl/burst_addr_rx.sv
// Memory-side receiver for the serial burst command stream: decodes mode, burst length and
// start address, then issues one address per beat over a valid/ready handshake.
module burst_addr_rx #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              ser_valid,
  input  logic              ser_sof,
  input  logic              abort,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              addr_last,
  output logic              burst_done,
  output logic              busy,
  output logic              frame_err
);

  localparam int FIELD_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
  localparam int CNT_W   = $clog2(FIELD_W + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MODE_CAP = 3'd1,
    LEN_RX   = 3'd2,
    ADDR_RX  = 3'd3,
    ISSUE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t              state_q, state_d, rx_state;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_sh_q, len_sh_d, len_full;
  logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d, addr_full;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                addr_valid_q, addr_valid_d;
  logic                addr_last_q, addr_last_d;
  logic                burst_done_q, burst_done_d;
  logic                frame_err_q, frame_err_d;
  logic                err_pend_q, err_pend_d;
  logic                busy_q, busy_d;
  logic                sof_hit, xfer;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    len_sh_d     = len_sh_q;
    addr_sh_d    = addr_sh_q;
    remaining_d  = remaining_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    addr_last_d  = addr_last_q;
    burst_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_pend_d   = 1'b0;

    sof_hit   = ser_valid & ser_sof;
    xfer      = addr_valid_q & addr_ready;
    len_full  = {len_sh_q[LEN_W-2:0], ser_in};
    addr_full = {addr_sh_q[ADDR_W-2:0], ser_in};

    // MODE_CAP already knows which field comes next, so it consumes that field's first bit
    rx_state = state_q;
    if (state_q == MODE_CAP) begin
      rx_state = mode_q ? LEN_RX : ADDR_RX;
    end

    if (abort) begin
      state_d      = IDLE;
      addr_valid_d = 1'b0;
      addr_last_d  = 1'b0;
      cnt_d        = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sof_hit) begin
            state_d = MODE_CAP;
            mode_d  = ser_in;
            cnt_d   = '0;
          end
        end
        MODE_CAP, LEN_RX, ADDR_RX: begin
          if (sof_hit) begin
            state_d = MODE_CAP;
            mode_d  = ser_in;
            cnt_d   = '0;
          end else begin
            state_d = rx_state;
            if (ser_valid && rx_state == LEN_RX) begin
              len_sh_d = len_full;
              if (cnt_q == CNT_W'(LEN_W - 1)) begin
                cnt_d   = '0;
                state_d = ADDR_RX;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end else if (ser_valid) begin
              addr_sh_d = addr_full;
              if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                cnt_d = '0;
                if (mode_q && len_sh_q == '0) begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
                end else begin
                  state_d      = ISSUE;
                  addr_d       = addr_full;
                  addr_valid_d = 1'b1;
                  remaining_d  = mode_q ? len_sh_q - 1'b1 : '0;
                  addr_last_d  = mode_q ? (len_sh_q == LEN_W'(1)) : 1'b1;
                end
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          frame_err_d = sof_hit;
          if (xfer) begin
            if (addr_last_q) begin
              addr_valid_d = 1'b0;
              addr_last_d  = 1'b0;
              burst_done_d = 1'b1;
              state_d      = DONE;
              // keep frame_err off the burst_done cycle; report the overrun one cycle later
              frame_err_d  = 1'b0;
              err_pend_d   = sof_hit;
            end else begin
              addr_d      = addr_q + 1'b1;
              remaining_d = remaining_q - 1'b1;
              addr_last_d = (remaining_q == LEN_W'(1));
            end
          end
        end
        DONE: begin
          frame_err_d = err_pend_q | sof_hit;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      len_sh_q     <= '0;
      addr_sh_q    <= '0;
      remaining_q  <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
      burst_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_pend_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      len_sh_q     <= len_sh_d;
      addr_sh_q    <= addr_sh_d;
      remaining_q  <= remaining_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      addr_last_q  <= addr_last_d;
      burst_done_q <= burst_done_d;
      frame_err_q  <= frame_err_d;
      err_pend_q   <= err_pend_d;
      busy_q       <= busy_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = addr_valid_q;
  assign addr_last  = addr_last_q;
  assign burst_done = burst_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
